// File: rtl/rv32_ex_pkg.sv
// Shared encodings for the RV32I execute stage.
// ALU ops, writeback selects, branch conditions and access sizes.
package rv32_ex_pkg;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] MTR_ALU = 2'b00;
   localparam logic [1:0] MTR_MEM = 2'b01;
   localparam logic [1:0] MTR_PC4 = 2'b10;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // mem_stage writes store data unshifted, so every lane carries a copy
   function automatic logic [31:0] store_lanes(
      input logic [1:0]  size,
      input logic [31:0] data
   );
      case (size)
         SZ_BYTE: return {4{data[7:0]}};
         SZ_HALF: return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational RV32I ALU and branch comparator.
module ex_alu
   import rv32_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] cmp_a,
   input  logic [XLEN-1:0] cmp_b,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result,
   output logic            taken
);

   logic [4:0] shamt;
   logic       lt_s;
   logic       lt_u;

   assign shamt = b[4:0];
   assign lt_s  = $signed(cmp_a) < $signed(cmp_b);
   assign lt_u  = cmp_a < cmp_b;

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_SLL:   result = a << shamt;
         ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:   result = a ^ b;
         ALU_SRL:   result = a >> shamt;
         ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
         ALU_OR:    result = a | b;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         BR_BEQ:  taken = cmp_a == cmp_b;
         BR_BNE:  taken = cmp_a != cmp_b;
         BR_BLT:  taken = lt_s;
         BR_BGE:  taken = ~lt_s;
         BR_BLTU: taken = lt_u;
         BR_BGEU: taken = ~lt_u;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and
// the registered EX/MEM boundary feeding mem_stage.
module ex_stage
   import rv32_ex_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [4:0]      id_rs1_addr_i,
   input  logic [4:0]      id_rs2_addr_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [4:0]      id_rd_addr_i,
   input  logic [3:0]      id_alu_op_i,
   input  logic            id_alu_src_a_i,
   input  logic            id_alu_src_b_i,
   input  logic            id_branch_i,
   input  logic            id_jal_i,
   input  logic            id_jalr_i,
   input  logic [2:0]      id_funct3_i,
   input  logic            id_regwrite_i,
   input  logic            id_memread_i,
   input  logic            id_memwrite_i,
   input  logic [1:0]      id_memtoreg_i,
   input  logic            wb_regwrite_i,
   input  logic [4:0]      wb_rd_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            regwrite_o,
   output logic [4:0]      rd_addr_o,
   output logic [1:0]      memtoreg_o,
   output logic [XLEN-1:0] pc_address_o,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] store_data_o,
   output logic            memread_o,
   output logic            memwrite_o,
   output logic [1:0]      mem_size_o,
   output logic            mem_unsigned_o,
   output logic            ex_valid_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] link;
   logic [XLEN-1:0] jalr_sum;
   logic [1:0]      size;
   logic            taken;
   logic            shadow;
   logic            own_ok;
   logic            valid;
   logic            redir_req;
   logic            tgt_mis;
   logic            mem_mis;
   logic            redir_next;

   // loads are not forwardable from here; decode handles load-use
   assign own_ok = regwrite_o & ex_valid_o & (memtoreg_o != MTR_MEM);

   always_comb begin
      rs1_fwd = id_rs1_data_i;
      if (id_rs1_addr_i != 5'd0) begin
         if (own_ok && rd_addr_o == id_rs1_addr_i)
            rs1_fwd = alu_result_o;
         else if (wb_regwrite_i && wb_rd_addr_i == id_rs1_addr_i)
            rs1_fwd = wb_data_i;
      end
   end

   always_comb begin
      rs2_fwd = id_rs2_data_i;
      if (id_rs2_addr_i != 5'd0) begin
         if (own_ok && rd_addr_o == id_rs2_addr_i)
            rs2_fwd = alu_result_o;
         else if (wb_regwrite_i && wb_rd_addr_i == id_rs2_addr_i)
            rs2_fwd = wb_data_i;
      end
   end

   assign op_a = id_alu_src_a_i ? id_pc_i : rs1_fwd;
   assign op_b = id_alu_src_b_i ? id_imm_i : rs2_fwd;

   ex_alu #(.XLEN(XLEN)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (id_alu_op_i),
      .cmp_a  (rs1_fwd),
      .cmp_b  (rs2_fwd),
      .funct3 (id_funct3_i),
      .result (alu_out),
      .taken  (taken)
   );

   assign link     = id_pc_i + 32'd4;
   assign jalr_sum = rs1_fwd + id_imm_i;
   assign target   = id_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0}
                               : id_pc_i + id_imm_i;
   assign size     = id_funct3_i[1:0];

   // the shadow flag kills the one instruction fetched behind a redirect
   assign valid     = id_valid_i & ~shadow;
   assign redir_req = valid & ((id_branch_i & taken) | id_jal_i | id_jalr_i);
   assign tgt_mis   = redir_req & (target[1:0] != 2'b00);
   assign mem_mis   = valid & (id_memread_i | id_memwrite_i) &
                      (((size == SZ_HALF) & alu_out[0]) |
                       ((size == SZ_WORD) & (alu_out[1:0] != 2'b00)));
   assign redir_next = redir_req & ~tgt_mis;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regwrite_o     <= 1'b0;
         rd_addr_o      <= '0;
         memtoreg_o     <= '0;
         pc_address_o   <= RESET_PC;
         alu_result_o   <= '0;
         store_data_o   <= '0;
         memread_o      <= 1'b0;
         memwrite_o     <= 1'b0;
         mem_size_o     <= '0;
         mem_unsigned_o <= 1'b0;
         ex_valid_o     <= 1'b0;
         redirect_o     <= 1'b0;
         redirect_pc_o  <= '0;
         misalign_o     <= 1'b0;
         shadow         <= 1'b0;
      end else if (flush_i) begin
         regwrite_o <= 1'b0;
         memread_o  <= 1'b0;
         memwrite_o <= 1'b0;
         ex_valid_o <= 1'b0;
         redirect_o <= 1'b0;
         misalign_o <= 1'b0;
         shadow     <= 1'b0;
      end else if (!stall_i) begin
         regwrite_o <= valid & id_regwrite_i &
                       (id_rd_addr_i != 5'd0) & ~tgt_mis;
         memread_o  <= valid & id_memread_i & ~mem_mis & ~tgt_mis;
         memwrite_o <= valid & id_memwrite_i & ~mem_mis & ~tgt_mis;
         ex_valid_o <= valid & ~tgt_mis;
         redirect_o <= redir_next;
         misalign_o <= tgt_mis | mem_mis;
         shadow     <= redir_next;
         rd_addr_o      <= id_rd_addr_i;
         memtoreg_o     <= id_memtoreg_i;
         pc_address_o   <= link;
         alu_result_o   <= (id_jal_i | id_jalr_i) ? link : alu_out;
         store_data_o   <= store_lanes(size, rs2_fwd);
         mem_size_o     <= size;
         mem_unsigned_o <= id_funct3_i[2];
         redirect_pc_o  <= target;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a
// behavioural model of the execute-stage rules.
module tb_ex_stage;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct packed {
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  mtr;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] sd;
      logic        mr;
      logic        mw;
      logic [1:0]  sz;
      logic        uns;
      logic        vld;
      logic        rdr;
      logic [31:0] rpc;
      logic        mis;
   } out_t;

   logic clk = 1'b0;
   logic rst_n, stall, flush, id_valid;
   logic [31:0] id_pc, rs1d, rs2d, imm, wbd;
   logic [4:0]  rs1a, rs2a, rd, wbrd;
   logic [3:0]  op;
   logic        sa, sb, br, jal, jalr, rw, mr, mw, wbrw;
   logic [2:0]  f3;
   logic [1:0]  mtr;

   out_t got, m, n;
   logic m_shadow, n_shadow;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .stall_i        (stall),
      .flush_i        (flush),
      .id_valid_i     (id_valid),
      .id_pc_i        (id_pc),
      .id_rs1_addr_i  (rs1a),
      .id_rs2_addr_i  (rs2a),
      .id_rs1_data_i  (rs1d),
      .id_rs2_data_i  (rs2d),
      .id_imm_i       (imm),
      .id_rd_addr_i   (rd),
      .id_alu_op_i    (op),
      .id_alu_src_a_i (sa),
      .id_alu_src_b_i (sb),
      .id_branch_i    (br),
      .id_jal_i       (jal),
      .id_jalr_i      (jalr),
      .id_funct3_i    (f3),
      .id_regwrite_i  (rw),
      .id_memread_i   (mr),
      .id_memwrite_i  (mw),
      .id_memtoreg_i  (mtr),
      .wb_regwrite_i  (wbrw),
      .wb_rd_addr_i   (wbrd),
      .wb_data_i      (wbd),
      .regwrite_o     (got.rw),
      .rd_addr_o      (got.rd),
      .memtoreg_o     (got.mtr),
      .pc_address_o   (got.pc),
      .alu_result_o   (got.alu),
      .store_data_o   (got.sd),
      .memread_o      (got.mr),
      .memwrite_o     (got.mw),
      .mem_size_o     (got.sz),
      .mem_unsigned_o (got.uns),
      .ex_valid_o     (got.vld),
      .redirect_o     (got.rdr),
      .redirect_pc_o  (got.rpc),
      .misalign_o     (got.mis)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      int signed   sa_i, sb_i;
      sh = int'(b[4:0]);
      sa_i = a;
      sb_i = b;
      case (o)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << sh;
         4'd3:    return (sa_i < sb_i) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> sh;
         4'd7:    return 32'(sa_i >>> sh);
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_br(input logic [2:0] c,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
      int signed x, y;
      x = a;
      y = b;
      case (c)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return x < y;
         3'b101:  return x >= y;
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [4:0] a,
                                        input logic [31:0] rf);
      if (a == 5'd0) return rf;
      if (m.rw && m.vld && m.mtr != 2'b01 && m.rd == a) return m.alu;
      if (wbrw && wbrd == a) return wbd;
      return rf;
   endfunction

   task automatic predict();
      logic [31:0] r1, r2, a, b, res, tgt, link;
      logic v, rq, tm, mm;
      n = m;
      n_shadow = m_shadow;
      if (flush) begin
         n.rw = 0; n.mr = 0; n.mw = 0;
         n.vld = 0; n.rdr = 0; n.mis = 0;
         n_shadow = 0;
      end else if (!stall) begin
         r1 = pick(rs1a, rs1d);
         r2 = pick(rs2a, rs2d);
         a = sa ? id_pc : r1;
         b = sb ? imm : r2;
         res = ref_alu(op, a, b);
         link = id_pc + 4;
         tgt = jalr ? ((r1 + imm) & 32'hFFFF_FFFE) : id_pc + imm;
         v = id_valid && !m_shadow;
         rq = v && ((br && ref_br(f3, r1, r2)) || jal || jalr);
         tm = rq && (tgt % 4 != 0);
         mm = v && (mr || mw) &&
              ((f3[1:0] == 2'd1 && res % 2 != 0) ||
               (f3[1:0] == 2'd2 && res % 4 != 0));
         n.vld = v && !tm;
         n.rdr = rq && !tm;
         n.rw = v && rw && rd != 0 && !tm;
         n.mr = v && mr && !mm && !tm;
         n.mw = v && mw && !mm && !tm;
         n.mis = tm || mm;
         n.rd = rd;
         n.mtr = mtr;
         n.pc = link;
         n.alu = (jal || jalr) ? link : res;
         if (f3[1:0] == 2'd0) n.sd = {4{r2[7:0]}};
         else if (f3[1:0] == 2'd1) n.sd = {2{r2[15:0]}};
         else n.sd = r2;
         n.sz = f3[1:0];
         n.uns = f3[2];
         n.rpc = tgt;
         n_shadow = n.rdr;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rw"}, 32'(got.rw), 32'(m.rw));
      chk({tag, ".rd"}, 32'(got.rd), 32'(m.rd));
      chk({tag, ".mtr"}, 32'(got.mtr), 32'(m.mtr));
      chk({tag, ".pc"}, got.pc, m.pc);
      chk({tag, ".alu"}, got.alu, m.alu);
      chk({tag, ".sd"}, got.sd, m.sd);
      chk({tag, ".mr"}, 32'(got.mr), 32'(m.mr));
      chk({tag, ".mw"}, 32'(got.mw), 32'(m.mw));
      chk({tag, ".sz"}, 32'(got.sz), 32'(m.sz));
      chk({tag, ".uns"}, 32'(got.uns), 32'(m.uns));
      chk({tag, ".vld"}, 32'(got.vld), 32'(m.vld));
      chk({tag, ".rdr"}, 32'(got.rdr), 32'(m.rdr));
      if (m.rdr) chk({tag, ".rpc"}, got.rpc, m.rpc);
      chk({tag, ".mis"}, 32'(got.mis), 32'(m.mis));
   endtask

   task automatic step(input string tag);
      predict();
      @(posedge clk);
      #1;
      m = n;
      m_shadow = n_shadow;
      check_all(tag);
   endtask

   task automatic model_reset();
      m = '0;
      m.pc = RST_PC;
      m_shadow = 0;
   endtask

   task automatic nop();
      stall = 0; flush = 0; id_valid = 0;
      id_pc = 0; rs1a = 0; rs2a = 0; rs1d = 0; rs2d = 0;
      imm = 0; rd = 0; op = 0; sa = 0; sb = 0;
      br = 0; jal = 0; jalr = 0; f3 = 0;
      rw = 0; mr = 0; mw = 0; mtr = 0;
      wbrw = 0; wbrd = 0; wbd = 0;
   endtask

   task automatic alu_ins(input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [31:0] im,
                          input logic use_imm);
      nop();
      id_valid = 1; id_pc = 32'h200;
      rd = d; rs1a = s1; rs2a = s2; imm = im; sb = use_imm;
      rw = 1; op = 4'd0;
   endtask

   task automatic rand_ins();
      logic [31:0] t;
      int k;
      nop();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = {20'h0, 10'($urandom), 2'b00};
      rs1a = 5'($urandom_range(0, 7));
      rs2a = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      rs1d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      rs2d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      t = $urandom;
      imm = {{25{t[6]}}, t[6:0]};
      op = 4'($urandom);
      sa = 1'($urandom);
      sb = 1'($urandom);
      f3 = 3'($urandom);
      wbrw = 1'($urandom);
      wbrd = 5'($urandom_range(0, 7));
      wbd = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0, 1: br = 1;
         2: begin jal = 1; rw = 1; mtr = 2'b10; end
         3: begin jalr = 1; rw = 1; mtr = 2'b10; end
         4, 5: begin mr = 1; rw = 1; mtr = 2'b01; op = 0; sb = 1; end
         6: begin mw = 1; op = 0; sb = 1; end
         default: rw = 1;
      endcase
   endtask

   initial begin
      nop();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset_pc", got.pc, RST_PC);
      rst_n = 1;

      alu_ins(5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      step("addi");
      alu_ins(5'd2, 5'd1, 5'd1, 32'd0, 1'b0);
      step("add_fwd");
      chk("fwd_alu", got.alu, 32'd10);
      chk("fwd_rd", 32'(got.rd), 32'd2);

      nop();
      id_valid = 1; id_pc = 32'h100; br = 1; f3 = 3'b000;
      rs1a = 5'd3; rs2a = 5'd4; rs1d = 7; rs2d = 7; imm = 32'h20;
      step("beq");
      chk("beq_rdr", 32'(got.rdr), 1);
      chk("beq_rpc", got.rpc, 32'h120);
      alu_ins(5'd5, 5'd0, 5'd0, 32'd9, 1'b1);
      step("shadow");
      chk("shadow_vld", 32'(got.vld), 0);
      chk("shadow_rw", 32'(got.rw), 0);
      chk("shadow_rdr", 32'(got.rdr), 0);

      nop();
      id_valid = 1; id_pc = 32'h40; jalr = 1; rs1a = 5'd6;
      rs1d = 32'h203; imm = 1; rd = 5'd7; rw = 1; mtr = 2'b10;
      step("jalr");
      chk("jalr_rpc", got.rpc, 32'h204);
      chk("jalr_link", got.alu, 32'h44);
      chk("jalr_mtr", 32'(got.mtr), 2);
      nop();
      step("jalr_kill");

      nop();
      id_valid = 1; mw = 1; sb = 1; f3 = 3'b000;
      rs1a = 5'd8; rs1d = 32'h1000; imm = 1;
      rs2a = 5'd9; rs2d = 32'h1234_56AB;
      step("sb");
      chk("sb_data", got.sd, 32'hABAB_ABAB);
      chk("sb_size", 32'(got.sz), 0);
      chk("sb_mw", 32'(got.mw), 1);
      f3 = 3'b010; imm = 2;
      step("sw_mis");
      chk("sw_mw", 32'(got.mw), 0);
      chk("sw_mis", 32'(got.mis), 1);

      nop();
      id_valid = 1; id_pc = 32'h300; br = 1; f3 = 3'b001;
      rs1a = 5'd10; rs2a = 5'd11; rs1d = 1; rs2d = 2; imm = 32'h40;
      step("bne");
      for (int i = 0; i < 3; i++) begin
         rand_ins();
         stall = 1; flush = 0;
         step("stall");
         chk("stall_rdr", 32'(got.rdr), 1);
         chk("stall_rpc", got.rpc, 32'h340);
      end
      stall = 1; flush = 1;
      step("flush");
      chk("flush_rdr", 32'(got.rdr), 0);
      chk("flush_vld", 32'(got.vld), 0);

      nop();
      id_valid = 1; id_pc = 32'h500; br = 1; f3 = 3'b001;
      rs1a = 5'd12; rs2a = 5'd13; rs1d = 3; rs2d = 4; imm = 32'h10;
      step("bne2");
      alu_ins(5'd3, 5'd0, 5'd0, 32'd1, 1'b1);
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("rst_pc", got.pc, RST_PC);
      chk("rst_rdr", 32'(got.rdr), 0);
      #1 rst_n = 1;
      step("post_rst");
      chk("post_rst_vld", 32'(got.vld), 1);

      for (int i = 0; i < 600; i++) begin
         rand_ins();
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
